register_file_sb: RTL and testbench

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 38 +++
 rtl/register_file_sb.sv | 94 +++++++++
 tb/tb_register_file_sb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the scoreboarded register file.
package regfile_pkg;
    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_NUM_REGS  = 16;
    localparam int DEFAULT_PC_OFFSET = 8;
    localparam int DEFAULT_IDX_W     = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets, write-back clears, issue wins on a tie.
// The PC alias index never reports busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int PC_IDX   = NUM_REGS - 1,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid_i,
    input  logic [IDX_W-1:0] issue_dest_i,
    input  logic             clear_en_i,
    input  logic [IDX_W-1:0] clear_idx_i,
    input  logic [IDX_W-1:0] rd_idx1_i,
    input  logic [IDX_W-1:0] rd_idx2_i,
    output logic             busy1_o,
    output logic             busy2_o
);
    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clear_en_i) busy_d[clear_idx_i] = 1'b0;
        // Set after clear so a same-cycle reissue keeps the bit.
        if (issue_valid_i) busy_d[issue_dest_i] = 1'b1;
        busy_d[PC_IDX] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy1_o = busy_q[rd_idx1_i];
    assign busy2_o = busy_q[rd_idx2_i];
endmodule

// File: rtl/register_file_sb.sv
// Register file with PC alias on reads, PC redirect on writes, and a busy scoreboard.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int PC_IDX    = NUM_REGS - 1,
    parameter int PC_OFFSET = DEFAULT_PC_OFFSET,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeEnable,
    input  logic [IDX_W-1:0]  writeDestination,
    input  logic [DATA_W-1:0] writeData,
    input  logic [IDX_W-1:0]  readReg1,
    input  logic [IDX_W-1:0]  readReg2,
    input  logic [DATA_W-1:0] oldPCVal,
    input  logic              issueValid,
    input  logic [IDX_W-1:0]  issueDest,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              busy1,
    output logic              busy2,
    output logic              stall,
    output logic              writeToPC,
    output logic [DATA_W-1:0] pcTarget
);
    localparam logic [IDX_W-1:0]  PC_SEL = IDX_W'(PC_IDX);
    localparam logic [DATA_W-1:0] PC_ADD = DATA_W'(PC_OFFSET);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              write_to_pc_q;
    logic [DATA_W-1:0] pc_target_q;
    logic              wr_pc, wr_arr;
    logic [DATA_W-1:0] pc_read, rd1, rd2;
    logic              sb_busy1, sb_busy2;

    assign wr_pc   = writeEnable && (writeDestination == PC_SEL);
    assign wr_arr  = writeEnable && (writeDestination != PC_SEL);
    assign pc_read = oldPCVal + PC_ADD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            write_to_pc_q <= 1'b0;
            pc_target_q   <= '0;
        end else begin
            if (wr_arr) regs_q[writeDestination] <= writeData;
            write_to_pc_q <= wr_pc;
            if (wr_pc) pc_target_q <= writeData;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .PC_IDX   (PC_IDX)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .issue_valid_i (issueValid),
        .issue_dest_i  (issueDest),
        .clear_en_i    (writeEnable),
        .clear_idx_i   (writeDestination),
        .rd_idx1_i     (readReg1),
        .rd_idx2_i     (readReg2),
        .busy1_o       (sb_busy1),
        .busy2_o       (sb_busy2)
    );

    assign rd1 = (readReg1 == PC_SEL) ? pc_read : regs_q[readReg1];
    assign rd2 = (readReg2 == PC_SEL) ? pc_read : regs_q[readReg2];

`ifdef REGFILE_BYPASS_EN
    logic byp1, byp2;
    // PC writes never bypass: wr_arr already excludes the alias index.
    assign byp1      = wr_arr && (readReg1 == writeDestination);
    assign byp2      = wr_arr && (readReg2 == writeDestination);
    assign readData1 = byp1 ? writeData : rd1;
    assign readData2 = byp2 ? writeData : rd2;
    assign busy1     = sb_busy1 & ~byp1;
    assign busy2     = sb_busy2 & ~byp2;
`else
    assign readData1 = rd1;
    assign readData2 = rd2;
    assign busy1     = sb_busy1;
    assign busy2     = sb_busy2;
`endif

    assign stall     = busy1 | busy2;
    assign writeToPC = write_to_pc_q;
    assign pcTarget  = pc_target_q;
endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: stimulus queues expectations, a monitor checks them.
module tb_register_file_sb;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    reg_idx_t    wdest = '0;
    logic [31:0] wdata = '0;
    reg_idx_t    rr1 = '0, rr2 = '0;
    logic [31:0] old_pc = '0;
    logic        iv = 1'b0;
    reg_idx_t    idest = '0;
    logic [31:0] rd1, rd2, pct;
    logic        busy1, busy2, stall, wpc;

    register_file_sb dut (
        .clk              (clk),
        .reset            (reset),
        .writeEnable      (we),
        .writeDestination (wdest),
        .writeData        (wdata),
        .readReg1         (rr1),
        .readReg2         (rr2),
        .oldPCVal         (old_pc),
        .issueValid       (iv),
        .issueDest        (idest),
        .readData1        (rd1),
        .readData2        (rd2),
        .busy1            (busy1),
        .busy2            (busy2),
        .stall            (stall),
        .writeToPC        (wpc),
        .pcTarget         (pct)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef enum {F_RD1, F_RD2, F_BUSY1, F_BUSY2, F_STALL, F_WPC, F_PCT} field_e;
    typedef struct {
        int          cyc;
        field_e      fld;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_v(input field_e f, input logic [31:0] e, input string n);
        chk_t c;
        c.cyc  = cyc_cnt;
        c.fld  = f;
        c.exp  = e;
        c.name = n;
        q.push_back(c);
    endtask

    function automatic logic [31:0] sample(input field_e f);
        case (f)
            F_RD1:   return rd1;
            F_RD2:   return rd2;
            F_BUSY1: return {31'b0, busy1};
            F_BUSY2: return {31'b0, busy2};
            F_STALL: return {31'b0, stall};
            F_WPC:   return {31'b0, wpc};
            default: return pct;
        endcase
    endfunction

    // Monitor: samples on the falling clock and on reset assertion, away from posedge.
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk or negedge reset);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
                c   = q.pop_front();
                act = sample(c.fld);
                n_checks++;
                if (c.cyc != cyc_cnt) begin
                    n_fail++;
                    $display("FAIL %s: not sampled in its cycle (queued %0d, now %0d)", c.name, c.cyc, cyc_cnt);
                end else if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", c.name, act, c.exp, cyc_cnt);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Writes and issues during reset must be discarded.
        we = 1'b1; wdest = 4'd1; wdata = 32'hDEAD_BEEF;
        iv = 1'b1; idest = 4'd4; rr1 = 4'd1; rr2 = 4'd4;
        step(); step();
        we = 1'b0; iv = 1'b0; reset = 1'b1;
        expect_v(F_RD1, 32'h0, "rst_r1_zero");
        expect_v(F_BUSY2, 32'h0, "rst_busy4_clear");
        expect_v(F_STALL, 32'h0, "rst_stall");
        expect_v(F_WPC, 32'h0, "rst_wpc");
        expect_v(F_PCT, 32'h0, "rst_pct");

        // R8 write then read.
        we = 1'b1; wdest = 4'd8; wdata = 32'hAAAA_AAAA; rr1 = 4'd8;
        expect_v(F_RD1, BYP ? 32'hAAAA_AAAA : 32'h0, "r8_same_cycle");
        step();
        we = 1'b0;
        expect_v(F_RD1, 32'hAAAA_AAAA, "r8_read");
        for (int i = 0; i < 15; i++) begin
            if (i != 8) begin
                rr2 = reg_idx_t'(i);
                expect_v(F_RD2, 32'h0, "other_reg_zero");
                step();
            end
        end

        // PC alias reads, including wrap.
        old_pc = 32'h0000_0100; rr2 = 4'd15;
        expect_v(F_RD2, 32'h0000_0108, "pc_read");
        step();
        old_pc = 32'hFFFF_FFFC;
        expect_v(F_RD2, 32'h0000_0004, "pc_read_wrap");

        // PC write: one-cycle redirect pulse, array untouched.
        we = 1'b1; wdest = 4'd15; wdata = 32'hCCCC_CCCC;
        expect_v(F_WPC, 32'h0, "wpc_not_yet");
        expect_v(F_RD2, 32'h0000_0004, "pc_write_no_bypass");
        step();
        we = 1'b0;
        expect_v(F_WPC, 32'h1, "wpc_pulse");
        expect_v(F_PCT, 32'hCCCC_CCCC, "pc_target");
        expect_v(F_RD2, 32'h0000_0004, "pc_alias_kept");
        step();
        expect_v(F_WPC, 32'h0, "wpc_one_cycle");

        // Issue / write-back on R3.
        iv = 1'b1; idest = 4'd3; rr1 = 4'd3; rr2 = 4'd5;
        expect_v(F_BUSY1, 32'h0, "busy_before_issue");
        step();
        iv = 1'b0;
        expect_v(F_BUSY1, 32'h1, "busy_after_issue");
        expect_v(F_STALL, 32'h1, "stall_after_issue");
        expect_v(F_BUSY2, 32'h0, "busy_other_clear");
        we = 1'b1; wdest = 4'd3; wdata = 32'h0000_0033;
        expect_v(F_BUSY1, BYP ? 32'h0 : 32'h1, "busy_during_wb");
        expect_v(F_RD1, BYP ? 32'h0000_0033 : 32'h0, "rd_during_wb");
        step();
        we = 1'b0;
        expect_v(F_BUSY1, 32'h0, "busy_after_wb");
        expect_v(F_STALL, 32'h0, "stall_after_wb");
        expect_v(F_RD1, 32'h0000_0033, "r3_after_wb");

        // Same-cycle issue and write-back: issue wins.
        iv = 1'b1; idest = 4'd3; we = 1'b1; wdest = 4'd3; wdata = 32'h0000_0044;
        step();
        iv = 1'b0; we = 1'b0;
        expect_v(F_BUSY1, 32'h1, "issue_wins");
        expect_v(F_RD1, 32'h0000_0044, "r3_tie_data");

        // Reissue while busy, then a single write-back clears.
        iv = 1'b1;
        step();
        iv = 1'b0;
        expect_v(F_BUSY1, 32'h1, "reissue_busy");
        we = 1'b1; wdata = 32'h0000_0045;
        step();
        we = 1'b0;
        expect_v(F_BUSY1, 32'h0, "single_wb_clears");

        // Issue to PC index is ignored.
        iv = 1'b1; idest = 4'd15; rr1 = 4'd15;
        step();
        iv = 1'b0;
        expect_v(F_BUSY1, 32'h0, "pc_never_busy");
        expect_v(F_STALL, 32'h0, "pc_no_stall");

        // Same-cycle write/read of R0.
        we = 1'b1; wdest = 4'd0; wdata = 32'h1234_5678; rr1 = 4'd0;
        expect_v(F_RD1, BYP ? 32'h1234_5678 : 32'h0, "r0_same_cycle");
        step();
        we = 1'b0;
        expect_v(F_RD1, 32'h1234_5678, "r0_next_cycle");

        // Asynchronous reset mid-sequence.
        iv = 1'b1; idest = 4'd5; we = 1'b1; wdest = 4'd2; wdata = 32'h0000_0055;
        step();
        iv = 1'b0; we = 1'b0; rr1 = 4'd2; rr2 = 4'd5;
        expect_v(F_RD1, 32'h0000_0055, "r2_before_reset");
        expect_v(F_BUSY2, 32'h1, "busy5_before_reset");
        @(negedge clk);
        #3;
        expect_v(F_RD1, 32'h0, "r2_async_reset");
        expect_v(F_BUSY2, 32'h0, "busy5_async_reset");
        expect_v(F_STALL, 32'h0, "stall_async_reset");
        reset = 1'b0;
        step();

        // First posedge after release operates normally.
        reset = 1'b1;
        we = 1'b1; wdest = 4'd6; wdata = 32'h0000_0066; rr1 = 4'd6;
        step();
        we = 1'b0;
        expect_v(F_RD1, 32'h0000_0066, "first_edge_after_reset");

        @(negedge clk);
        #3;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: %0d entries left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
